// File: rtl/timer_pkg.sv
// Shared types and helpers for the timer / stop_watch family.
// Holds the FSM state encoding and the unsigned load-value clamp.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    PAUSED = 2'd2,
    DONE   = 2'd3
  } timer_state_e;

  // Unsigned min(); callers zero-extend to 64 bits and truncate the result.
  function automatic logic [63:0] clamp_u(input logic [63:0] value, input logic [63:0] max_val);
    return (value > max_val) ? max_val : value;
  endfunction

endpackage

// File: rtl/countdown_timer.sv
// Load-and-run down-counter with expiry pulse and optional auto-reload.
// Zero-cycle start latency (first decrement on the start edge); no backpressure.
module countdown_timer
  import timer_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 16,
  parameter int unsigned MAX         = 99,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [DATA_WIDTH-1:0] load_value,
  input  logic                  start,
  input  logic                  stop,
  output logic [DATA_WIDTH-1:0] count,
  output logic                  busy,
  output logic                  done,
  output logic                  expired
);

  if (DATA_WIDTH < 1 || DATA_WIDTH > 63 || 64'(MAX) > ((64'd1 << DATA_WIDTH) - 64'd1)) begin : g_bad_params
    $error("countdown_timer: MAX must fit in DATA_WIDTH bits (DATA_WIDTH 1..63)");
  end

  localparam logic [DATA_WIDTH-1:0] ONE = DATA_WIDTH'(1);

  timer_state_e          state_q, state_d;
  logic [DATA_WIDTH-1:0] count_q, count_d;
  logic [DATA_WIDTH-1:0] reload_q, reload_d;
  logic                  expired_q, expired_d;
  logic [DATA_WIDTH-1:0] load_clamped;

  assign load_clamped = DATA_WIDTH'(clamp_u(64'(load_value), 64'(MAX)));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      expired_q <= expired_d;
    end
  end

  // Priority load > stop > start; stop also masks a simultaneous start in every state.
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    if (load) begin
      state_d  = IDLE;
      count_d  = load_clamped;
      reload_d = load_clamped;
    end else if (stop) begin
      if (state_q == RUN) state_d = PAUSED;
    end else begin
      case (state_q)
        IDLE, PAUSED: begin
          if (start && count_q != '0) begin
            state_d = RUN;
            count_d = count_q - ONE;
          end
        end
        RUN: begin
          if (count_q > ONE) begin
            count_d = count_q - ONE;
          end else if (count_q == ONE) begin
            count_d   = '0;
            expired_d = 1'b1;
            state_d   = (AUTO_RELOAD && reload_q != '0) ? RUN : DONE;
          end else begin
            count_d = reload_q;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    count   = count_q;
    busy    = (state_q == RUN);
    done    = (state_q == DONE);
    expired = expired_q;
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Directed bench for countdown_timer: one-shot instance (a) and auto-reload instance (b).
module tb_countdown_timer;

  logic        clk;
  logic        resetn;
  logic        load_a, start_a, stop_a;
  logic [15:0] load_value_a;
  logic [15:0] count_a;
  logic        busy_a, done_a, expired_a;
  logic        load_b, start_b, stop_b;
  logic [15:0] load_value_b;
  logic [15:0] count_b;
  logic        busy_b, done_b, expired_b;

  int checks = 0;
  int errors = 0;

  countdown_timer #(.DATA_WIDTH(16), .MAX(99), .AUTO_RELOAD(1'b0)) u_a (
    .clk(clk), .resetn(resetn), .load(load_a), .load_value(load_value_a),
    .start(start_a), .stop(stop_a), .count(count_a), .busy(busy_a),
    .done(done_a), .expired(expired_a)
  );

  countdown_timer #(.DATA_WIDTH(16), .MAX(99), .AUTO_RELOAD(1'b1)) u_b (
    .clk(clk), .resetn(resetn), .load(load_b), .load_value(load_value_b),
    .start(start_b), .stop(stop_b), .count(count_b), .busy(busy_b),
    .done(done_b), .expired(expired_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_a(input string tag, input int c, input bit b, input bit d, input bit e);
    chk({tag, ".count"}, 32'(count_a), 32'(c));
    chk({tag, ".busy"}, 32'(busy_a), 32'(b));
    chk({tag, ".done"}, 32'(done_a), 32'(d));
    chk({tag, ".expired"}, 32'(expired_a), 32'(e));
  endtask

  task automatic chk_b(input string tag, input int c, input bit e);
    chk({tag, ".count"}, 32'(count_b), 32'(c));
    chk({tag, ".busy"}, 32'(busy_b), 32'd1);
    chk({tag, ".done"}, 32'(done_b), 32'd0);
    chk({tag, ".expired"}, 32'(expired_b), 32'(e));
  endtask

  initial begin
    int seq_b [6];
    seq_b = '{1, 0, 2, 1, 0, 2};
    resetn = 1'b0;
    load_a = 0; start_a = 0; stop_a = 0; load_value_a = '0;
    load_b = 0; start_b = 0; stop_b = 0; load_value_b = '0;
    #2;
    chk_a("reset", 0, 0, 0, 0);
    #10 resetn = 1'b1;

    // One-shot countdown from 3
    tick();
    load_a = 1; load_value_a = 16'd3;
    tick(); load_a = 0;
    chk_a("load3", 3, 0, 0, 0);
    start_a = 1;
    tick(); start_a = 0;
    chk_a("run2", 2, 1, 0, 0);
    tick(); chk_a("run1", 1, 1, 0, 0);
    tick(); chk_a("run0", 0, 0, 1, 1);
    start_a = 1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk_a("donehold", 0, 0, 1, 0);
    end
    start_a = 0;

    // Pause and resume
    load_a = 1; load_value_a = 16'd10;
    tick(); load_a = 0;
    start_a = 1;
    tick(); start_a = 0;
    chk_a("r10", 9, 1, 0, 0);
    tick(); tick();
    chk_a("r10b", 7, 1, 0, 0);
    stop_a = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk_a("paused", 7, 0, 0, 0);
    end
    stop_a = 0; start_a = 1;
    tick(); start_a = 0;
    chk_a("resume", 6, 1, 0, 0);

    // start+stop together in RUN: stop wins
    start_a = 1; stop_a = 1;
    tick(); stop_a = 0;
    chk_a("startstop", 6, 0, 0, 0);
    // load with start: load wins, no decrement
    load_a = 1; load_value_a = 16'd5; start_a = 1;
    tick(); load_a = 0; start_a = 0;
    chk_a("loadstart", 5, 0, 0, 0);
    tick();
    chk_a("idlehold", 5, 0, 0, 0);

    // Clamp boundaries
    load_a = 1; load_value_a = 16'd200;
    tick(); chk_a("clamp200", 99, 0, 0, 0);
    load_value_a = 16'd100;
    tick(); chk_a("clamp100", 99, 0, 0, 0);
    load_value_a = 16'd99;
    tick(); chk_a("clamp99", 99, 0, 0, 0);
    load_value_a = 16'd98;
    tick(); chk_a("clamp98", 98, 0, 0, 0);
    load_value_a = 16'hFFFF;
    tick(); chk_a("clampmax", 99, 0, 0, 0);
    // start with count 0 in IDLE is ignored
    load_value_a = 16'd0;
    tick(); load_a = 0;
    chk_a("load0", 0, 0, 0, 0);
    start_a = 1;
    tick(); chk_a("start0a", 0, 0, 0, 0);
    tick(); start_a = 0;
    chk_a("start0b", 0, 0, 0, 0);

    // Auto-reload periodic ticks
    load_b = 1; load_value_b = 16'd2;
    tick(); load_b = 0;
    start_b = 1;
    for (int i = 0; i < 6; i++) begin
      tick(); start_b = 0;
      chk_b("autoreload", seq_b[i], seq_b[i] == 0);
    end

    // Asynchronous reset mid-run
    load_a = 1; load_value_a = 16'd5;
    tick(); load_a = 0;
    start_a = 1;
    tick(); start_a = 0;
    tick();
    chk_a("prereset", 3, 1, 0, 0);
    #2 resetn = 1'b0;
    #1 chk_a("asyncrst", 0, 0, 0, 0);
    chk("asyncrst.b", 32'(count_b), 32'd0);
    #2 resetn = 1'b1;
    tick();
    start_a = 1;
    tick();
    chk_a("postrst1", 0, 0, 0, 0);
    tick(); start_a = 0;
    chk_a("postrst2", 0, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
